// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int DEF_A          = 32;
    localparam int DEF_L          = 8;
    localparam int DEF_STARVE_MAX = 15;
    localparam int DEF_LOCK_MAX   = 16;

    typedef enum logic {
        IDLE_ARB  = 1'b0,
        HOST_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arb_picker.sv
// Grant selection between CPU and host; DMEM_ARB_RR_EN selects round-robin tie-break.
// Latency: purely combinational, grants valid in the request cycle.
// Backpressure: at most one grant per cycle; the loser simply sees gnt low and holds.
module dmem_arb_picker
    import dmem_arb_pkg::*;
(
    input  logic       arb_en,
    input  arb_state_t state,
    input  logic       cpu_req,
    input  logic       host_req,
    input  logic       cpu_first,
`ifdef DMEM_ARB_RR_EN
    input  owner_t     last_owner,
`else
    input  logic       starve_full,
`endif
    output logic       cpu_gnt,
    output logic       host_gnt
);

    logic host_wins_tie;

`ifdef DMEM_ARB_RR_EN
    // Round-robin: the side that did not win last time takes the tie.
    assign host_wins_tie = (last_owner == OWN_CPU);
`else
    // Fixed priority: host only takes a tie once it has waited long enough.
    assign host_wins_tie = starve_full;
`endif

    // Pick at most one winner; a locked host excludes the CPU entirely.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (arb_en) begin
            if (state == HOST_LOCK) begin
                host_gnt = host_req;
            end else if (cpu_req && host_req) begin
                // cpu_first repays the CPU after a full-length host lock.
                if (!cpu_first && host_wins_tie) begin
                    host_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt  = cpu_req;
                host_gnt = host_req;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for CPU MEM stage and host loader; DMEM_ARB_RR_EN selects round-robin.
// Latency: grant and mem_* drive are combinational; read data returns with rvalid one cycle later.
// Backpressure: requesters hold until gnt; a locked host owns memory for up to LOCK_MAX beats.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int A          = DEF_A,
    parameter int L          = DEF_L,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int LOCK_MAX   = DEF_LOCK_MAX
)
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [A-1:0] cpu_addr_i,
    input  logic [L-1:0] cpu_wdata_i,
    output logic         cpu_gnt_o,
    output logic         cpu_rvalid_o,
    output logic [L-1:0] cpu_rdata_o,
    input  logic         host_req_i,
    input  logic         host_we_i,
    input  logic         host_lock_i,
    input  logic [A-1:0] host_addr_i,
    input  logic [L-1:0] host_wdata_i,
    output logic         host_gnt_o,
    output logic         host_rvalid_o,
    output logic [L-1:0] host_rdata_o,
    output logic [A-1:0] mem_address_o,
    output logic [L-1:0] mem_in_data_o,
    output logic         mem_WE_o,
    input  logic [L-1:0] mem_out_data_i
);

    localparam int            LW        = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_MAX);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

    arb_state_t    state, state_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;
    logic          cpu_first, cpu_first_nxt;
    logic          cpu_gnt, host_gnt;
    logic          cpu_rd_q, host_rd_q;
    logic [A-1:0]  addr_q;
    logic [L-1:0]  wdata_q;

`ifdef DMEM_ARB_RR_EN
    owner_t last_owner;

    // Remember the most recent winner for the round-robin tie-break; CPU goes first after reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_owner <= OWN_HOST;
        end else if (cpu_gnt) begin
            last_owner <= OWN_CPU;
        end else if (host_gnt) begin
            last_owner <= OWN_HOST;
        end
    end
`else
    localparam int            SW          = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          starve_full;

    assign starve_full = (starve_cnt == STARVE_LAST);

    // Count cycles the host waits without a grant, saturating; any host grant clears it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            starve_cnt <= '0;
        end else if (host_gnt) begin
            starve_cnt <= '0;
        end else if (host_req_i && !starve_full) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    dmem_arb_picker u_picker (
        .arb_en      (RST),
        .state       (state),
        .cpu_req     (cpu_req_i),
        .host_req    (host_req_i),
        .cpu_first   (cpu_first),
`ifdef DMEM_ARB_RR_EN
        .last_owner  (last_owner),
`else
        .starve_full (starve_full),
`endif
        .cpu_gnt     (cpu_gnt),
        .host_gnt    (host_gnt)
    );

    // Lock FSM: host lock entry, beat counting and the three exit conditions.
    always_comb begin
        state_nxt     = state;
        lock_nxt      = lock_cnt;
        cpu_first_nxt = cpu_first;
        if (cpu_first && (cpu_gnt || host_gnt)) begin
            cpu_first_nxt = 1'b0;
        end
        case (state)
            IDLE_ARB: begin
                if (host_gnt && host_lock_i) begin
                    if (LOCK_LAST <= LOCK_ONE) begin
                        // A one-beat lock is already exhausted by this grant.
                        cpu_first_nxt = 1'b1;
                    end else begin
                        state_nxt = HOST_LOCK;
                        lock_nxt  = LOCK_ONE;
                    end
                end
            end
            HOST_LOCK: begin
                if (!host_req_i) begin
                    state_nxt = IDLE_ARB;
                    lock_nxt  = '0;
                end else if (host_gnt) begin
                    lock_nxt = lock_cnt + 1'b1;
                    if (!host_lock_i) begin
                        state_nxt = IDLE_ARB;
                        lock_nxt  = '0;
                    end else if ((lock_cnt + 1'b1) == LOCK_LAST) begin
                        state_nxt     = IDLE_ARB;
                        lock_nxt      = '0;
                        cpu_first_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE_ARB;
                lock_nxt  = '0;
            end
        endcase
    end

    // FSM and lock bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE_ARB;
            lock_cnt  <= '0;
            cpu_first <= 1'b0;
        end else begin
            state     <= state_nxt;
            lock_cnt  <= lock_nxt;
            cpu_first <= cpu_first_nxt;
        end
    end

    // Track which requester owns the read data returning next cycle; writes return nothing.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cpu_rd_q  <= 1'b0;
            host_rd_q <= 1'b0;
        end else begin
            cpu_rd_q  <= cpu_gnt && !cpu_we_i;
            host_rd_q <= host_gnt && !host_we_i;
        end
    end

    // Hold the last driven address/data so the memory bus is quiet between beats.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= mem_address_o;
            wdata_q <= mem_in_data_o;
        end
    end

    assign cpu_gnt_o  = cpu_gnt;
    assign host_gnt_o = host_gnt;

    assign mem_WE_o      = (cpu_gnt && cpu_we_i) || (host_gnt && host_we_i);
    assign mem_address_o = !RST     ? '0          :
                           cpu_gnt  ? cpu_addr_i  :
                           host_gnt ? host_addr_i : addr_q;
    assign mem_in_data_o = !RST     ? '0           :
                           cpu_gnt  ? cpu_wdata_i  :
                           host_gnt ? host_wdata_i : wdata_q;

    // Gating with RST drops a read that was in flight when reset arrived.
    assign cpu_rvalid_o  = cpu_rd_q && RST;
    assign host_rvalid_o = host_rd_q && RST;
    assign cpu_rdata_o   = cpu_rvalid_o  ? mem_out_data_i : '0;
    assign host_rdata_o  = host_rvalid_o ? mem_out_data_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency memory model.
// Latency: memory read data registered one cycle after the address.
// Backpressure: requesters hold their request until gnt is seen.
module tb_dmem_arbiter;

    localparam int A  = 32;
    localparam int L  = 8;
    localparam int G_NONE = 0;
    localparam int G_HOST = 1;
    localparam int G_CPU  = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         cpu_req, cpu_we, host_req, host_we, host_lock;
    logic [A-1:0] cpu_addr, host_addr;
    logic [L-1:0] cpu_wdata, host_wdata;
    logic         cpu_gnt_o, cpu_rvalid_o, host_gnt_o, host_rvalid_o, mem_WE_o;
    logic [L-1:0] cpu_rdata_o, host_rdata_o, mem_in_data_o;
    logic [A-1:0] mem_address_o;
    logic [L-1:0] mem_out_data_i;
    logic [1:0]   gnts;

    logic [L-1:0] mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.A(A), .L(L), .STARVE_MAX(15), .LOCK_MAX(16)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .cpu_req_i      (cpu_req),
        .cpu_we_i       (cpu_we),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_gnt_o      (cpu_gnt_o),
        .cpu_rvalid_o   (cpu_rvalid_o),
        .cpu_rdata_o    (cpu_rdata_o),
        .host_req_i     (host_req),
        .host_we_i      (host_we),
        .host_lock_i    (host_lock),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .host_gnt_o     (host_gnt_o),
        .host_rvalid_o  (host_rvalid_o),
        .host_rdata_o   (host_rdata_o),
        .mem_address_o  (mem_address_o),
        .mem_in_data_o  (mem_in_data_o),
        .mem_WE_o       (mem_WE_o),
        .mem_out_data_i (mem_out_data_i)
    );

    assign gnts = {cpu_gnt_o, host_gnt_o};

    // Synchronous memory: write on the edge, read data one cycle after the address.
    always @(posedge CLK) begin
        if (mem_WE_o) mem[mem_address_o[7:0]] <= mem_in_data_o;
        mem_out_data_i <= mem[mem_address_o[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
    endtask

    task automatic cpu_drive(input logic we, input logic [A-1:0] addr, input logic [L-1:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic host_drive(input logic we, input logic lock, input logic [A-1:0] addr, input logic [L-1:0] wd);
        host_req = 1'b1; host_we = we; host_lock = lock; host_addr = addr; host_wdata = wd;
    endtask

    initial begin
        int hi;
        logic cpu_done;
        int exp_g;
        idle_inputs();
        cpu_addr = '0; host_addr = '0; cpu_wdata = '0; host_wdata = '0;

        // Reset with both sides requesting: everything must stay quiet.
        cpu_drive(1'b1, 32'h33, 8'h77);
        host_drive(1'b0, 1'b1, 32'h44, 8'h66);
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check("rst_gnt",   32'(gnts), G_NONE);
        check("rst_we",    32'(mem_WE_o), 0);
        check("rst_addr",  32'(mem_address_o), 0);
        check("rst_wdata", 32'(mem_in_data_o), 0);
        check("rst_rvld",  32'({cpu_rvalid_o, host_rvalid_o}), 0);
        check("rst_rdata", 32'({cpu_rdata_o, host_rdata_o}), 0);
        next_cycle();
        RST = 1'b1;
        idle_inputs();

        // Host write 0x5A to 0x10.
        host_drive(1'b1, 1'b0, 32'h10, 8'h5A);
        @(negedge CLK);
        check("hw_gnt",   32'(gnts), G_HOST);
        check("hw_we",    32'(mem_WE_o), 1);
        check("hw_addr",  32'(mem_address_o), 32'h10);
        check("hw_wdata", 32'(mem_in_data_o), 32'h5A);
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        check("hw_no_rvld", 32'(host_rvalid_o), 0);
        check("idle_we",    32'(mem_WE_o), 0);
        check("idle_hold",  32'(mem_address_o), 32'h10);
        next_cycle();

        // CPU read 0x10, CPU write 0xAA@5, host read 5, CPU read 5: back-to-back beats.
        cpu_drive(1'b0, 32'h10, 8'h00);
        @(negedge CLK);
        check("cr_gnt",  32'(gnts), G_CPU);
        check("cr_addr", 32'(mem_address_o), 32'h10);
        check("cr_we",   32'(mem_WE_o), 0);
        next_cycle();
        cpu_drive(1'b1, 32'h5, 8'hAA);
        @(negedge CLK);
        check("cw_gnt",   32'(gnts), G_CPU);
        check("cw_we",    32'(mem_WE_o), 1);
        check("cw_wdata", 32'(mem_in_data_o), 32'hAA);
        check("cr_rvld",  32'({cpu_rvalid_o, host_rvalid_o}), 2);
        check("cr_rdata", 32'(cpu_rdata_o), 32'h5A);
        next_cycle();
        cpu_req = 1'b0;
        host_drive(1'b0, 1'b0, 32'h5, 8'h00);
        @(negedge CLK);
        check("hr_gnt",     32'(gnts), G_HOST);
        check("cw_no_rvld", 32'({cpu_rvalid_o, host_rvalid_o}), 0);
        next_cycle();
        host_req = 1'b0;
        cpu_drive(1'b0, 32'h5, 8'h00);
        @(negedge CLK);
        check("cr2_gnt",  32'(gnts), G_CPU);
        check("hr_rvld",  32'({cpu_rvalid_o, host_rvalid_o}), 1);
        check("hr_rdata", 32'(host_rdata_o), 32'hAA);
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        check("cr2_rvld",  32'({cpu_rvalid_o, host_rvalid_o}), 2);
        check("cr2_rdata", 32'(cpu_rdata_o), 32'hAA);
        check("cr2_hold",  32'(mem_address_o), 32'h5);
        next_cycle();

`ifndef DMEM_ARB_RR_EN
        // Both request continuously: host wins every 16th cycle through starvation.
        cpu_drive(1'b0, 32'h10, 8'h00);
        host_drive(1'b0, 1'b0, 32'h5, 8'h00);
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            check($sformatf("starve_c%0d", c), 32'(gnts), (c % 16 == 15) ? G_HOST : G_CPU);
            if (c == 16) check("starve_hdata", 32'(host_rdata_o), 32'hAA);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
`endif

        // Locked host burst of 20 writes with the CPU waiting from the second beat.
        hi = 0;
        cpu_done = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (hi < 20) host_drive(1'b1, 1'b1, 32'(hi), 8'(hi));
            else host_req = 1'b0;
            if (c >= 1 && !cpu_done) cpu_drive(1'b0, 32'h10, 8'h00);
            else cpu_req = 1'b0;
            @(negedge CLK);
            exp_g = (c == 16) ? G_CPU : (c == 21) ? G_NONE : G_HOST;
            check($sformatf("lock_c%0d", c), 32'(gnts), exp_g);
            if (c == 17) check("lock_cpu_rdata", 32'({cpu_rvalid_o, cpu_rdata_o}), 32'h15A);
            if (host_gnt_o) hi++;
            if (cpu_gnt_o) cpu_done = 1'b1;
            next_cycle();
        end
        idle_inputs();

        // Lock released by host_req low: CPU alone is granted, and reads back burst data.
        cpu_drive(1'b0, 32'd19, 8'h00);
        @(negedge CLK);
        check("unlock_gnt", 32'(gnts), G_CPU);
        next_cycle();
        cpu_drive(1'b0, 32'd15, 8'h00);
        @(negedge CLK);
        check("burst_rd19", 32'({cpu_rvalid_o, cpu_rdata_o}), 32'h113);
        next_cycle();
        idle_inputs();
        @(negedge CLK);
        check("burst_rd15", 32'({cpu_rvalid_o, cpu_rdata_o}), 32'h10F);
        next_cycle();

        // Host locked read granted, then reset the next cycle: no rvalid, state cleared.
        host_drive(1'b0, 1'b1, 32'h5, 8'h00);
        @(negedge CLK);
        check("pre_rst_gnt", 32'(gnts), G_HOST);
        next_cycle();
        RST = 1'b0;
        cpu_drive(1'b0, 32'h10, 8'h00);
        host_drive(1'b0, 1'b0, 32'h5, 8'h00);
        @(negedge CLK);
        check("rst_hrvld",   32'(host_rvalid_o), 0);
        check("rst_gnt2",    32'(gnts), G_NONE);
        check("rst_hrdata",  32'(host_rdata_o), 0);
        next_cycle();
        next_cycle();
        RST = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
`ifdef DMEM_ARB_RR_EN
            exp_g = (c % 2 == 1) ? G_HOST : G_CPU;
`else
            exp_g = (c == 15) ? G_HOST : G_CPU;
`endif
            check($sformatf("post_rst_c%0d", c), 32'(gnts), exp_g);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter A, default 32, meaning the data-memory address width.
REQ-002 The block SHALL have parameter L, default 8, meaning the data-memory word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 15, meaning the host wait-cycle limit before host priority is forced.
REQ-004 The block SHALL have parameter LOCK_MAX, default 16, meaning the maximum consecutive locked host beats.
REQ-005 The block SHALL have a single clock and a synchronous active-low reset, with ports as follows:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-low reset.
- cpu_req_i  input  1  CPU MEM-stage access request.
- cpu_we_i  input  1  CPU write enable (1 = write).
- cpu_addr_i  input  A  CPU address.
- cpu_wdata_i  input  L  CPU write data.
- cpu_gnt_o  output  1  CPU access accepted this cycle.
- cpu_rvalid_o  output  1  CPU read data valid.
- cpu_rdata_o  output  L  CPU read data.
- host_req_i  input  1  host (loader/dump) request.
- host_we_i  input  1  host write enable.
- host_lock_i  input  1  host requests to keep ownership after this beat.
- host_addr_i  input  A  host address.
- host_wdata_i  input  L  host write data.
- host_gnt_o  output  1  host access accepted this cycle.
- host_rvalid_o  output  1  host read data valid.
- host_rdata_o  output  L  host read data.
- mem_address_o  output  A  data-memory address.
- mem_in_data_o  output  L  data-memory write data.
- mem_WE_o  output  1  data-memory write enable.
- mem_out_data_i  input  L  data-memory read data, valid one cycle after the address.

Function
REQ-006 Requesters SHALL hold req/we/addr/wdata stable until their gnt is sampled high; each gnt SHALL complete exactly one beat.
REQ-007 At most one gnt SHALL be high per cycle; in that cycle the mem_* outputs SHALL combinationally carry the winner's address, write data and we.
REQ-008 With no grant, mem_WE_o SHALL be 0 and mem_address_o SHALL hold its last value.
REQ-009 A granted read SHALL produce a one-cycle rvalid in cycle t+1 to the cycle-t winner only, with rdata = mem_out_data_i; a granted write SHALL produce no rvalid.
REQ-010 Back-to-back beats SHALL be supported, one per cycle, including a read-to-other-requester switch.
REQ-011 The FSM states SHALL be IDLE_ARB, HOST_LOCK.
REQ-012 In IDLE_ARB, when both requesters request, the CPU SHALL win unless the starvation counter has reached STARVE_MAX.
REQ-013 The starvation counter SHALL increment each cycle host_req_i is high and not granted, clear on a host grant, and saturate at STARVE_MAX.
REQ-014 A host grant with host_lock_i=1 SHALL move the FSM to HOST_LOCK and load the lock-beat count with 1.
REQ-015 In HOST_LOCK, only the host SHALL be granted, and each host grant SHALL increment the lock-beat count.
REQ-016 HOST_LOCK SHALL return to IDLE_ARB after a host grant with host_lock_i=0, after the grant that brings the lock-beat count to LOCK_MAX, or in any cycle with host_req_i=0.
REQ-017 After a LOCK_MAX exit with cpu_req_i high, the next grant SHALL go to the CPU.

Reset
REQ-018 While RST=0, the FSM SHALL be in IDLE_ARB, both counters SHALL be 0, and all gnt, rvalid and mem_WE_o outputs SHALL be 0.
REQ-019 While RST=0, rdata SHALL be 0, and mem_address_o and mem_in_data_o SHALL be 0.
REQ-020 A read granted in the cycle before reset asserts SHALL produce no rvalid.

Configuration
REQ-021 With DMEM_ARB_RR_EN defined, IDLE_ARB SHALL use round-robin: on a tie the requester not granted most recently SHALL win (CPU after reset), and the starvation counter SHALL be absent.
REQ-022 Without DMEM_ARB_RR_EN, the fixed priority with starvation override of REQ-012 and REQ-013 SHALL apply.

Structure
REQ-023 The package dmem_arb_pkg SHALL hold the FSM state enum, the owner enum (OWN_CPU, OWN_HOST), and the default A, L, STARVE_MAX and LOCK_MAX constants.
REQ-024 The grant selection logic SHALL be the sub-module dmem_arb_picker, and all other state SHALL live in dmem_arbiter.

Verification
REQ-025 CPU read addr 0x10 with memory content 0x5A: cpu_gnt_o in cycle t, cpu_rvalid_o with 0x5A in cycle t+1, and host_rvalid_o SHALL stay 0.
REQ-026 Both requesters request continuously (fixed priority), CPU reads: the host SHALL be granted on exactly the 16th cycle and the CPU in all others.
REQ-027 Host writes 0x00..0x13 to addresses 0..19 with host_lock_i=1 while the CPU requests: 16 consecutive host grants, then one CPU grant, then the host resumes.
REQ-028 CPU write 0xAA to addr 5, then host read of addr 5 the next cycle: the host SHALL receive 0xAA.
REQ-029 Host read granted in cycle t with RST=0 in cycle t+1: host_rvalid_o SHALL stay 0, and the FSM and counters SHALL be cleared.
REQ-030 With DMEM_ARB_RR_EN defined and both requesters requesting continuously: grants SHALL alternate CPU, host, CPU, host starting from reset.
